// File: rtl/mapped_timer_bank.sv
// Bank of CHANNELS 16-bit prescaled up-counters with compare match and irq.
// Decodes its own word window; reads outside it return zero for OR-combining.
module mapped_timer_bank #(
  parameter logic [13:0] BASE_ADDR = 14'h0020,
  parameter int          CHANNELS  = 4
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic [13:0]         i_memAddr,
  input  logic [15:0]         i_memDataIn,
  input  logic                i_memWrEn,
  output logic [15:0]         o_memDataOut,
  input  logic                i_pause,
  output logic [CHANNELS-1:0] o_irq
);

  logic [CHANNELS-1:0] en;
  logic [CHANNELS-1:0] ar;
  logic [CHANNELS-1:0] ie;
  logic [CHANNELS-1:0] match;
  logic [7:0]          presc [CHANNELS];
  logic [7:0]          pre   [CHANNELS];
  logic [15:0]         count [CHANNELS];
  logic [15:0]         cmp   [CHANNELS];

  logic [13:0]         off;
  logic                in_win;
  logic [2:0]          ch;
  logic [1:0]          rsel;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] wsel;

  // Addresses below BASE_ADDR wrap to large offsets and fall outside.
  assign off    = i_memAddr - BASE_ADDR;
  assign in_win = off < 14'(4 * CHANNELS);
  assign ch     = off[4:2];
  assign rsel   = off[1:0];

  always_comb begin
    tick = '0;
    hit  = '0;
    wsel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tick[c] = en[c] & ~i_pause & (pre[c] == presc[c]);
      hit[c]  = count[c] == cmp[c];
      wsel[c] = i_memWrEn & in_win & (ch == 3'(c));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      en    <= '0;
      ar    <= '0;
      ie    <= '0;
      match <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        presc[c] <= '0;
        pre[c]   <= '0;
        count[c] <= '0;
        cmp[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (wsel[c] && rsel == 2'd0) begin
          en[c]    <= i_memDataIn[0];
          ar[c]    <= i_memDataIn[1];
          ie[c]    <= i_memDataIn[2];
          presc[c] <= i_memDataIn[15:8];
          pre[c]   <= '0;
        end else begin
          if (en[c] && !i_pause)
            pre[c] <= tick[c] ? 8'd0 : pre[c] + 8'd1;
          if (tick[c] && hit[c] && !ar[c])
            en[c] <= 1'b0;
        end

        if (wsel[c] && rsel == 2'd1)
          count[c] <= i_memDataIn;
        else if (tick[c] && hit[c] && ar[c])
          count[c] <= '0;
        else if (tick[c] && !hit[c])
          count[c] <= count[c] + 16'd1;

        if (wsel[c] && rsel == 2'd2)
          cmp[c] <= i_memDataIn;

        // A match on the same edge outranks a software clear.
        if (tick[c] && hit[c])
          match[c] <= 1'b1;
        else if (wsel[c] && rsel == 2'd3 && i_memDataIn[0])
          match[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    o_memDataOut = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_win && ch == 3'(c)) begin
        case (rsel)
          2'd0:    o_memDataOut = {presc[c], 5'b0, ie[c], ar[c], en[c]};
          2'd1:    o_memDataOut = count[c];
          2'd2:    o_memDataOut = cmp[c];
          default: o_memDataOut = {15'b0, match[c]};
        endcase
      end
    end
  end

  assign o_irq = match & ie;

endmodule

// File: tb/tb_mapped_timer_bank.sv
// Directed bench for mapped_timer_bank: reset, free-run, one-shot,
// wrap, pause, same-edge priorities and mid-count reset.
module tb_mapped_timer_bank;

  localparam logic [13:0] B  = 14'h0020;
  localparam int          CH = 4;

  logic        clk;
  logic        rstn;
  logic [13:0] addr;
  logic [15:0] din;
  logic        wr_en;
  logic [15:0] dout;
  logic        pause;
  logic [CH-1:0] irq;

  int n_chk;
  int n_fail;

  mapped_timer_bank #(.BASE_ADDR(B), .CHANNELS(CH)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_memAddr   (addr),
    .i_memDataIn (din),
    .i_memWrEn   (wr_en),
    .o_memDataOut(dout),
    .i_pause     (pause),
    .o_irq       (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [13:0] a, input logic [15:0] d);
    addr  = a;
    din   = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [13:0] a,
                      input logic [15:0] exp);
    addr = a;
    #1;
    check(tag, 32'(dout), 32'(exp));
  endtask

  task automatic all_zero(input string tag);
    for (int a = int'(B) - 1; a <= int'(B) + 4 * CH; a++) begin
      addr = 14'(a);
      #1;
      check(tag, 32'(dout), 32'h0);
    end
    check({tag, "_irq"}, 32'(irq), 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    addr   = '0;
    din    = '0;
    wr_en  = 1'b0;
    pause  = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    all_zero("reset");

    // ch0 free-running with auto-reload
    bus_wr(B + 2, 16'd3);
    bus_wr(B + 1, 16'd0);
    bus_wr(B + 0, 16'h0007);
    rchk("c0_start", B + 1, 16'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      rchk($sformatf("c0_cnt%0d", i), B + 1, 16'(i));
    end
    rchk("c0_nomatch", B + 3, 16'd0);
    step();
    rchk("c0_reload", B + 1, 16'd0);
    rchk("c0_match", B + 3, 16'd1);
    check("c0_irq", 32'(irq[0]), 32'd1);
    bus_wr(B + 3, 16'h0001);
    rchk("c0_clr", B + 3, 16'd0);
    check("c0_irq_clr", 32'(irq[0]), 32'd0);
    bus_wr(B + 0, 16'h0000);

    // ch1 one-shot, PRESC=3
    bus_wr(B + 6, 16'd1);
    bus_wr(B + 4, 16'h0301);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) rchk("c1_pre3", B + 5, 16'd0);
      if (k == 4) rchk("c1_inc4", B + 5, 16'd1);
      if (k == 7) rchk("c1_nomatch7", B + 7, 16'd0);
      if (k == 8) begin
        rchk("c1_match8", B + 7, 16'd1);
        rchk("c1_en_off", B + 4, 16'h0300);
      end
      if (k == 12) rchk("c1_hold", B + 5, 16'd1);
    end

    // ch2 wrap then match
    bus_wr(B + 9, 16'hFFFF);
    bus_wr(B + 10, 16'h0005);
    bus_wr(B + 8, 16'h0001);
    step();
    rchk("c2_wrap", B + 9, 16'h0000);
    rchk("c2_wrap_nf", B + 11, 16'd0);
    repeat (5) step();
    rchk("c2_cnt5", B + 9, 16'd5);
    rchk("c2_pre_match", B + 11, 16'd0);
    step();
    rchk("c2_match", B + 11, 16'd1);
    rchk("c2_hold", B + 9, 16'd5);

    // ch3 pause and COUNT write on a tick edge
    bus_wr(B + 14, 16'h1000);
    bus_wr(B + 12, 16'h0201);
    repeat (5) step();
    rchk("c3_before_pause", B + 13, 16'd1);
    pause = 1'b1;
    repeat (5) step();
    rchk("c3_paused", B + 13, 16'd1);
    pause = 1'b0;
    step();
    rchk("c3_resume", B + 13, 16'd2);
    step();
    step();
    bus_wr(B + 13, 16'h0100);
    rchk("c3_wr_wins", B + 13, 16'h0100);
    repeat (3) step();
    rchk("c3_after_wr", B + 13, 16'h0101);

    // ch0 STATUS clear lands on the match edge
    bus_wr(B + 2, 16'd2);
    bus_wr(B + 1, 16'd0);
    bus_wr(B + 0, 16'h0007);
    step();
    step();
    bus_wr(B + 3, 16'h0001);
    rchk("c0_set_wins", B + 3, 16'd1);
    check("c0_set_irq", 32'(irq[0]), 32'd1);
    rchk("c0_reload2", B + 1, 16'd0);

    // reset mid-count
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    all_zero("midreset");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
